// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 transmitter.
// Sends one command byte to the keyboard over the shared open-drain clock and
// data pair: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop,
// then the device ACK. Any stall in device clocking aborts the transfer with
// error set, so the firmware never waits on a dead or missing keyboard.
//
// Request handshake: txStart is a one-cycle request. It is accepted only in a
// cycle where busy=0 and done=0. On acceptance txData is latched and busy rises
// on the next edge. Requests made while busy (or in the done cycle) are dropped
// without effect. done pulses for one cycle when the transfer ends, and error,
// which is valid with done, holds its value until the next accepted request.
`timescale 1ns/1ps

module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t           state;
  logic             clk_s1;
  logic             clk_s2;
  logic             clk_s3;
  logic             data_s1;
  logic             data_s2;
  logic             fall;
  logic [9:0]       frame;
  logic [3:0]       bit_idx;
  logic [INH_W-1:0] cnt;
  logic [TMO_W-1:0] tmo;

  // Bring the asynchronous line levels into the clk domain; idle level is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2ClkIn;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2DataIn;
      data_s2 <= data_s1;
    end
  end

  // Device clock falling edge as seen by the synchronized clock line.
  assign fall = clk_s3 & ~clk_s2;

  assign state_dbg = state;

  // Transfer sequencer; every line-drive and status output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ps2ClkOe  <= 1'b0;
      ps2DataOe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      frame     <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      tmo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          ps2ClkOe  <= 1'b0;
          ps2DataOe <= 1'b0;
          // done is high only in the first IDLE cycle, so a request there is dropped.
          if (txStart && !done) begin
            frame    <= {1'b1, ~^txData, txData};
            busy     <= 1'b1;
            error    <= 1'b0;
            cnt      <= '0;
            ps2ClkOe <= 1'b1;
            state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          ps2ClkOe <= 1'b1;
          if (cnt == INH_LAST) begin
            // Start bit goes out while the clock is still held low.
            ps2DataOe <= 1'b1;
            state     <= S_REQUEST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_REQUEST: begin
          // Releasing the clock hands control of clocking to the device.
          ps2ClkOe <= 1'b0;
          bit_idx  <= '0;
          tmo      <= '0;
          state    <= S_SHIFT;
        end

        S_SHIFT: begin
          if (fall) begin
            // Change data while the device clock is low; it samples on the rise.
            ps2DataOe <= ~frame[bit_idx];
            tmo       <= '0;
            if (bit_idx == 4'd9) begin
              state <= S_ACK;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else if (tmo == TMO_LAST) begin
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_ACK: begin
          if (fall) begin
            // Device pulls data low to acknowledge; a high level is a NACK.
            error <= data_s2;
            tmo   <= '0;
            state <= S_WAIT_IDLE;
          end else if (tmo == TMO_LAST) begin
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (fall) begin
            tmo <= '0;
          end else if (tmo == TMO_LAST) begin
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        default: begin
          ps2ClkOe  <= 1'b0;
          ps2DataOe <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural PS/2 keyboard drives the
// device clock, samples each host bit on the rising edge and optionally ACKs.
`timescale 1ns/1ps

module tb_ps2_host_transmitter;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 8;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] frame;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2ClkOe;
  logic       ps2DataOe;
  logic [7:0] txData;
  logic       txStart;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state_dbg;

  logic dev_clk;
  logic dev_data_low;
  logic clk_line;
  logic data_line;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Open-drain wired-AND of host and device drivers.
  assign clk_line  = ~ps2ClkOe & dev_clk;
  assign data_line = ~ps2DataOe & ~dev_data_low;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2ClkIn(clk_line),
    .ps2DataIn(data_line),
    .ps2ClkOe(ps2ClkOe),
    .ps2DataOe(ps2DataOe),
    .txData(txData),
    .txStart(txStart),
    .busy(busy),
    .done(done),
    .error(error),
    .state_dbg(state_dbg)
  );

  // Clock and done-pulse monitor.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    txData  = d;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
  endtask

  // Device model: waits for the host to release the clock, then produces
  // n_clocks clock pulses. got[k] is the line sampled at rise k+1.
  task automatic device_frame(input int n_clocks, input bit do_ack,
                              output logic [9:0] got, output logic start_low);
    bit seen_inh = 0;
    bit released = 0;
    got = '0;
    start_low = 1'b1;
    for (int k = 0; k < INH + 20; k++) begin
      @(negedge clk);
      if (ps2ClkOe) seen_inh = 1;
      if (seen_inh && !ps2ClkOe) begin
        released = 1;
        break;
      end
    end
    check("host_release_seen", {31'd0, released}, 32'd1);
    if (!released) return;
    start_low = data_line;
    for (int i = 0; i < n_clocks; i++) begin
      if (i == 10 && do_ack) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i < 10) got[i] = data_line;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input bit inject,
                           output bit seen, output logic err, output int waited);
    seen = 0;
    err = 1'bx;
    waited = budget;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        err = error;
        waited = k;
        if (inject) begin
          txData  = 8'hFF;
          txStart = 1'b1;
        end
        break;
      end
    end
  endtask

  // One complete transfer against the device model, compared with v.
  task automatic run_vector(input vec_t v, input bit inject);
    logic [9:0] got;
    logic start_low;
    bit seen;
    logic err;
    int waited;
    pulse_start(v.data);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("error_cleared_on_start", {31'd0, error}, 32'd0);
    device_frame(11, v.ack, got, start_low);
    check("start_bit_low", {31'd0, start_low}, 32'd0);
    check("frame_bits", {22'd0, got}, {22'd0, v.frame});
    wait_done(50, inject, seen, err, waited);
    check("done_seen", {31'd0, seen}, 32'd1);
    check("error_with_done", {31'd0, err}, {31'd0, v.err});
    @(negedge clk);
    if (inject) begin
      txStart = 1'b0;
      check("start_in_done_cycle_ignored", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("still_idle_after_ignored", {29'd0, state_dbg}, 32'd0);
    end
    check("busy_low_after_done", {31'd0, busy}, 32'd0);
    check("lines_released", {30'd0, ps2ClkOe, ps2DataOe}, 32'd0);
    check("error_held", {31'd0, error}, {31'd0, v.err});
  endtask

  vec_t vecs[7];

  initial begin
    logic [9:0] got;
    logic start_low;
    bit seen;
    logic err;
    int waited;
    int dc;

    // Hand-computed frames: {stop=1, odd parity, data}.
    vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 10'h300, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 10'h201, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 10'h3A5, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 10'h280, 1'b0};
    vecs[5] = '{8'h55, 1'b0, 10'h355, 1'b1};
    vecs[6] = '{8'hED, 1'b1, 10'h3ED, 1'b0};

    reset = 1'b1;
    txData = 8'h00;
    txStart = 1'b0;
    dev_clk = 1'b1;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, ps2ClkOe, ps2DataOe, busy, done, error}, 32'd0);
    check("reset_state_idle", {29'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vector(vecs[i], 1'b0);

    // Requests while busy are ignored; the line still carries 0xED.
    txData = 8'hED;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    fork
      device_frame(11, 1'b1, got, start_low);
      begin
        repeat (8) @(negedge clk);
        pulse_start(8'hFF);
        repeat (60) @(negedge clk);
        pulse_start(8'hFF);
      end
    join
    check("retrigger_frame", {22'd0, got}, 32'h3ED);
    wait_done(50, 1'b0, seen, err, waited);
    check("retrigger_done", {30'd0, seen, err}, 32'd2);
    repeat (2) @(negedge clk);

    // Device stops clocking after 4 bits of 0x33; bit 3 is 0 so data stays driven.
    pulse_start(8'h33);
    device_frame(4, 1'b0, got, start_low);
    check("timeout_partial_bits", {28'd0, got[3:0]}, 32'h3);
    check("data_driven_before_timeout", {31'd0, ps2DataOe}, 32'd1);
    wait_done(TMO + 50, 1'b0, seen, err, waited);
    check("timeout_done", {30'd0, seen, err}, 32'd3);
    check("timeout_latency_window", {31'd0, (waited >= TMO - HALF - 6) && (waited <= TMO)}, 32'd1);
    check("timeout_state_idle", {29'd0, state_dbg}, 32'd0);
    check("timeout_lines_released", {30'd0, ps2ClkOe, ps2DataOe}, 32'd0);
    @(negedge clk);
    check("timeout_busy_low", {31'd0, busy}, 32'd0);
    run_vector(vecs[0], 1'b0);

    // Request in the done cycle is dropped.
    run_vector(vecs[3], 1'b1);

    // Async reset during SHIFT: 0x00 drives data low after the third fall.
    pulse_start(8'h00);
    device_frame(3, 1'b0, got, start_low);
    check("reset_test_bits", {29'd0, got[2:0]}, 32'd0);
    check("data_driven_before_reset", {31'd0, ps2DataOe}, 32'd1);
    dc = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_lines", {29'd0, ps2ClkOe, ps2DataOe, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_across_reset", done_cnt, dc);
    check("idle_after_reset", {29'd0, state_dbg}, 32'd0);
    run_vector(vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound.
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
